// File: rtl/frame_update_scheduler.sv
// Polls the object-update units once per vertical blank over req/ack, then commits
// every staged coordinate into the renderer-facing shadow registers in a single cycle.
module frame_update_scheduler #(
  parameter int N_OBJ       = 4,
  parameter int Y_VBLANK    = 515,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 ativo,
  input  logic [9:0]           VGA_Y,
  input  logic [N_OBJ-1:0]     upd_ack,
  input  logic [10*N_OBJ-1:0]  obj_x_in,
  input  logic [10*N_OBJ-1:0]  obj_y_in,
  output logic [N_OBJ-1:0]     upd_req,
  output logic [10*N_OBJ-1:0]  obj_x_out,
  output logic [10*N_OBJ-1:0]  obj_y_out,
  output logic                 commit,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic                 timeout_err,
  output logic                 overrun
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_vb_q, in_vb_prev_q;
  logic [10*N_OBJ-1:0] stage_x_q, stage_x_d, stage_y_q, stage_y_d;
  logic [10*N_OBJ-1:0] obj_x_q, obj_x_d, obj_y_q, obj_y_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                timeout_q, timeout_d, overrun_q, overrun_d;

  logic                vb_edge, cur_ack, ack_expired, last_obj;
  logic [N_OBJ-1:0]    take;

  assign vb_edge     = in_vb_q & ~in_vb_prev_q;
  assign cur_ack     = upd_ack[idx_q];
  assign ack_expired = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign last_obj    = (idx_q == IDX_W'(N_OBJ - 1));

  // Only the currently requested object may load its staging slot.
  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_take
    assign take[gi] = (state_q == S_REQ) && (idx_q == IDX_W'(gi)) && upd_ack[gi];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      in_vb_q       <= 1'b0;
      in_vb_prev_q  <= 1'b0;
      stage_x_q     <= '0;
      stage_y_q     <= '0;
      obj_x_q       <= '0;
      obj_y_q       <= '0;
      frame_count_q <= '0;
      timeout_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      in_vb_q       <= (VGA_Y >= 10'(Y_VBLANK));
      in_vb_prev_q  <= in_vb_q;
      stage_x_q     <= stage_x_d;
      stage_y_q     <= stage_y_d;
      obj_x_q       <= obj_x_d;
      obj_y_q       <= obj_y_d;
      frame_count_q <= frame_count_d;
      timeout_q     <= timeout_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (vb_edge && ativo) begin
          state_d = S_REQ;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (cur_ack || ack_expired) begin
          cnt_d = '0;
          if (last_obj) state_d = S_COMMIT;
          else          idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A timed-out object keeps its staged value, which equals its last committed one.
  always_comb begin
    stage_x_d = stage_x_q;
    stage_y_d = stage_y_q;
    for (int i = 0; i < N_OBJ; i++) begin
      if (take[i]) begin
        stage_x_d[i*10 +: 10] = obj_x_in[i*10 +: 10];
        stage_y_d[i*10 +: 10] = obj_y_in[i*10 +: 10];
      end
    end
    obj_x_d       = (state_q == S_COMMIT) ? stage_x_q : obj_x_q;
    obj_y_d       = (state_q == S_COMMIT) ? stage_y_q : obj_y_q;
    frame_count_d = (state_q == S_COMMIT) ? frame_count_q + 16'd1 : frame_count_q;
    timeout_d     = timeout_q | ((state_q == S_REQ) && !cur_ack && ack_expired);
    overrun_d     = overrun_q | (vb_edge && (state_q != S_IDLE));
  end

  always_comb begin
    upd_req = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      upd_req[i] = (state_q == S_REQ) && (idx_q == IDX_W'(i));
    end
    commit = (state_q == S_COMMIT);
    busy   = (state_q != S_IDLE);
  end

  assign obj_x_out   = obj_x_q;
  assign obj_y_out   = obj_y_q;
  assign frame_count = frame_count_q;
  assign timeout_err = timeout_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed and randomized passes of the frame update scheduler, checked against a
// pass-level model: per-object hold times, commit timing and committed coordinates.
module tb_frame_update_scheduler;

  localparam int N     = 4;
  localparam int TMO   = 255;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ativo = 1'b0;
  logic [9:0]  VGA_Y = 10'd514;
  logic [3:0]  upd_ack = '0;
  logic [39:0] obj_x_in = '0;
  logic [39:0] obj_y_in = '0;
  logic [3:0]  upd_req;
  logic [39:0] obj_x_out, obj_y_out;
  logic        commit, busy, timeout_err, overrun;
  logic [15:0] frame_count;

  frame_update_scheduler dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .ativo       (ativo),
    .VGA_Y       (VGA_Y),
    .upd_ack     (upd_ack),
    .obj_x_in    (obj_x_in),
    .obj_y_in    (obj_y_in),
    .upd_req     (upd_req),
    .obj_x_out   (obj_x_out),
    .obj_y_out   (obj_y_out),
    .commit      (commit),
    .busy        (busy),
    .frame_count (frame_count),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int ack_delay [N];
  int hold_cnt  [N];
  int sx [N];
  int sy [N];
  int m_frame;
  bit m_tout, m_ovr;

  // Requester model: each unit acks once its req has been high for ack_delay cycles.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (upd_req[i]) begin
        hold_cnt[i]++;
        upd_ack[i] = (hold_cnt[i] >= ack_delay[i]);
      end else begin
        hold_cnt[i] = 0;
        upd_ack[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y);
    obj_x_in[i*10 +: 10] = x[9:0];
    obj_y_in[i*10 +: 10] = y[9:0];
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    ack_delay[0] = d0;
    ack_delay[1] = d1;
    ack_delay[2] = d2;
    ack_delay[3] = d3;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sx[i] = 0;
      sy[i] = 0;
    end
    m_frame = 0;
    m_tout  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [39:0] ex, ey;
    for (int i = 0; i < N; i++) begin
      ex[i*10 +: 10] = sx[i][9:0];
      ey[i*10 +: 10] = sy[i][9:0];
    end
    check({tag, ".obj_x"}, 64'(obj_x_out), 64'(ex));
    check({tag, ".obj_y"}, 64'(obj_y_out), 64'(ey));
    check({tag, ".frame"}, 64'(frame_count), 64'(m_frame[15:0]));
    check({tag, ".tout"},  64'(timeout_err), 64'(m_tout));
    check({tag, ".ovr"},   64'(overrun), 64'(m_ovr));
    check({tag, ".busy"},  64'(busy), 64'(0));
  endtask

  task automatic run_pass(input string tag, input bit inject_ovr, input bit drop_act);
    int obs_h [N];
    int exp_h [N];
    int sum_h, commits, commit_c, last_idx, c, inj_c;
    bit order_ok, onehot_ok, injected;
    for (int i = 0; i < N; i++) begin
      obs_h[i] = 0;
      exp_h[i] = (ack_delay[i] < TMO) ? ack_delay[i] : TMO;
    end
    sum_h = 0;
    for (int i = 0; i < N; i++) sum_h += exp_h[i];
    commits = 0; commit_c = -1; last_idx = 0; c = 0; inj_c = 0;
    order_ok = 1'b1; onehot_ok = 1'b1; injected = 1'b0;
    VGA_Y = 10'd514;
    tick();
    tick();
    VGA_Y = 10'd515;
    tick();
    while (c < 2000 && (commit_c < 0 || c < commit_c + 4)) begin
      tick();
      c++;
      if ($countones(upd_req) > 1) onehot_ok = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (upd_req[i]) begin
          obs_h[i]++;
          if (i < last_idx) order_ok = 1'b0;
          last_idx = i;
        end
      end
      if (commit) begin
        commits++;
        commit_c = c;
      end
      if (inject_ovr && !injected && upd_req == 4'b0010) begin
        VGA_Y = 10'd514;
        injected = 1'b1;
        inj_c = c;
      end
      if (injected && c == inj_c + 2) VGA_Y = 10'd515;
      if (drop_act && upd_req == 4'b0010) ativo = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s.hold%0d", tag, i), 64'(obs_h[i]), 64'(exp_h[i]));
    end
    check({tag, ".onehot"},   64'(onehot_ok), 64'(1));
    check({tag, ".order"},    64'(order_ok), 64'(1));
    check({tag, ".pulses"},   64'(commits), 64'(1));
    check({tag, ".commit_c"}, 64'(commit_c), 64'(1 + sum_h));
    for (int i = 0; i < N; i++) begin
      if (ack_delay[i] <= TMO) begin
        sx[i] = int'(obj_x_in[i*10 +: 10]);
        sy[i] = int'(obj_y_in[i*10 +: 10]);
      end else begin
        m_tout = 1'b1;
      end
    end
    m_frame = (m_frame + 1) % 65536;
    if (inject_ovr) m_ovr = 1'b1;
    check_state(tag);
  endtask

  initial begin
    int seen;
    bit quiet;
    model_reset();
    set_delays(1, 1, 1, 1);

    // Reset held two cycles: everything cleared.
    reset = 1'b1;
    tick();
    tick();
    check("rst.req",    64'(upd_req), 64'(0));
    check("rst.commit", 64'(commit), 64'(0));
    check_state("rst");
    reset = 1'b0;
    tick();

    // A vblank edge with the game stopped is ignored entirely.
    VGA_Y = 10'd515;
    quiet = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (upd_req != 4'b0000 || commit || busy) quiet = 1'b0;
    end
    check("idle.quiet", 64'(quiet), 64'(1));
    check_state("idle");

    // Basic pass, acks one cycle after each req.
    ativo = 1'b1;
    for (int i = 0; i < N; i++) set_obj(i, 10 + i, 20 + i);
    run_pass("basic", 1'b0, 1'b0);
    check("basic.xconst", 64'(obj_x_out), 64'({10'd13, 10'd12, 10'd11, 10'd10}));

    // Object 2 never acks: it is skipped after 255 cycles and keeps its old value.
    for (int i = 0; i < N; i++) set_obj(i, 100 + i, 200 + i);
    set_delays(1, 2, NEVER, 1);
    run_pass("tmo", 1'b0, 1'b0);

    // Ack on the very last allowed cycle still counts.
    for (int i = 0; i < N; i++) set_obj(i, 300 + i, 400 + i);
    set_delays(1, 1, TMO, 1);
    run_pass("edge255", 1'b0, 1'b0);

    // Second vblank edge during a pass: flagged and dropped.
    for (int i = 0; i < N; i++) set_obj(i, 500 + i, 600 + i);
    set_delays(1, 6, 1, 1);
    run_pass("ovr", 1'b1, 1'b0);

    // Game stops mid-pass: the pass still completes.
    for (int i = 0; i < N; i++) set_obj(i, 700 + i, 800 + i);
    set_delays(2, 2, 2, 2);
    run_pass("drop", 1'b0, 1'b1);
    ativo = 1'b1;

    // Randomized passes.
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < N; i++) begin
        int d;
        set_obj(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        d = int'($urandom_range(1, 7));
        ack_delay[i] = (d == 7) ? NEVER : d;
      end
      run_pass($sformatf("rnd%0d", p), 1'b0, 1'b0);
    end

    // Reset while object 2 is being requested: pass abandoned, no commit.
    set_delays(1, 1, NEVER, 1);
    VGA_Y = 10'd514;
    tick();
    tick();
    VGA_Y = 10'd515;
    tick();
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      tick();
      if (upd_req == 4'b0100) seen = 1;
    end
    check("midrst.reached", 64'(seen), 64'(1));
    reset = 1'b1;
    VGA_Y = 10'd514;
    tick();
    model_reset();
    check("midrst.req",    64'(upd_req), 64'(0));
    check("midrst.commit", 64'(commit), 64'(0));
    check_state("midrst");
    reset = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (commit || upd_req != 4'b0000) quiet = 1'b0;
    end
    check("midrst.quiet", 64'(quiet), 64'(1));

    // frame_count wraps from 65535 to 0.
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tick();
    m_frame = 65535;
    set_delays(1, 1, 1, 1);
    for (int i = 0; i < N; i++) set_obj(i, 40 + i, 50 + i);
    run_pass("wrap", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
